// File: rtl/fir_pkg.sv
// Shared FIR constants and types used by the coefficient loader and the filter core.
package fir_pkg;

  localparam int ORDER = 53;
  localparam int WIDTH = 16;

  typedef logic signed [WIDTH-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } loader_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// One bank of N coefficient registers: single write port, flat read bus of all taps.
module fir_coef_bank #(
  parameter int N = 53,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] widx,
  input  logic [W-1:0]         wdata,
  output logic [N*W-1:0]       rd_bus
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_rd
    assign rd_bus[k*W +: W] = mem[k];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Serial-to-parallel coefficient loader with a shadow bank that goes live on the
// filter's sample-boundary strobe, so the datapath never sees a partial set.
//
//   state | meaning
//   IDLE  | waiting for tap 0, count = 0
//   LOAD  | collecting taps into the shadow bank
//   ARMED | full set in shadow, waiting for swap_en
module fir_coef_loader #(
  parameter int ORDER = fir_pkg::ORDER,
  parameter int WIDTH = fir_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   coef_valid,
  input  logic [WIDTH-1:0]       coef_data,
  input  logic                   coef_last,
  output logic                   coef_ready,
  input  logic                   swap_en,
  output logic [ORDER*WIDTH-1:0] coeffs_out,
  output logic                   load_done,
  output logic                   load_err
);

  import fir_pkg::*;

  localparam int CW = $clog2(ORDER);
  localparam logic [CW-1:0] LAST_IDX = CW'(ORDER - 1);

  loader_state_t   state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bank_sel_q, bank_sel_d;
  logic            done_d, err_d;
  logic            accept;
  logic [ORDER*WIDTH-1:0] bus0, bus1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      bank_sel_q <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bank_sel_q <= bank_sel_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bank_sel_d = bank_sel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    coef_ready = (state_q != ARMED);
    accept     = coef_valid && coef_ready;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (coef_last && count_q == LAST_IDX) begin
            state_d = ARMED;
            count_d = '0;
          end else if (coef_last || count_q == LAST_IDX) begin
            // short or overlong set: drop it, the active bank is untouched
            err_d   = 1'b1;
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      ARMED: begin
        if (swap_en) begin
          bank_sel_d = ~bank_sel_q;
          done_d     = 1'b1;
          count_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Only the shadow bank (the one not selected) is ever written.
  fir_coef_bank #(.N(ORDER), .W(WIDTH)) u_bank0 (
    .clk    (clk),
    .reset  (reset),
    .we     (accept && bank_sel_q),
    .widx   (count_q),
    .wdata  (coef_data),
    .rd_bus (bus0)
  );

  fir_coef_bank #(.N(ORDER), .W(WIDTH)) u_bank1 (
    .clk    (clk),
    .reset  (reset),
    .we     (accept && !bank_sel_q),
    .widx   (count_q),
    .wdata  (coef_data),
    .rd_bus (bus1)
  );

  assign coeffs_out = bank_sel_q ? bus1 : bus0;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: expected load_done/load_err events are queued
// by the stimulus and checked by a negedge monitor against coeffs_out.
module tb_fir_coef_loader;
  import fir_pkg::*;

  localparam int N    = ORDER;
  localparam int W    = WIDTH;
  localparam int FLAT = N * W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            coef_valid = 1'b0;
  logic [W-1:0]    coef_data = '0;
  logic            coef_last = 1'b0;
  logic            swap_en = 1'b0;
  logic            coef_ready;
  logic [FLAT-1:0] coeffs_out;
  logic            load_done;
  logic            load_err;

  fir_coef_loader #(.ORDER(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_last  (coef_last),
    .coef_ready (coef_ready),
    .swap_en    (swap_en),
    .coeffs_out (coeffs_out),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            is_err;
    logic [FLAT-1:0] coeffs;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  int              n_pass = 0;
  int              n_total = 0;
  logic [FLAT-1:0] model_active = '0;

  function automatic logic [W-1:0] tap_val(input int mode, input int k);
    case (mode)
      0:       return W'(k + 1);
      1:       return W'(-(k + 1) * 7);
      2:       return W'(32768 + k * 257);
      3:       return W'(k * 1000 - 26000);
      4:       return W'(32767 - k);
      5:       return W'(k * k);
      6:       return W'(k * 613 + 11);
      default: return W'(k ^ 23130);
    endcase
  endfunction

  function automatic logic [FLAT-1:0] pack_set(input int mode);
    logic [FLAT-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[k*W +: W] = tap_val(mode, k);
    return f;
  endfunction

  task automatic check(input string name, input logic [FLAT-1:0] got, input logic [FLAT-1:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the edge on which it is accepted.
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int n;
    coef_data  = d;
    coef_last  = last;
    coef_valid = 1'b1;
    n = 0;
    while (!coef_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL beat_timeout: coef_ready stayed %b, want 1", coef_ready);
    end
    @(posedge clk);
    #1;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic send_beats(input int mode, input int first, input int cnt,
                            input bit last_at_end, input int max_gap);
    for (int k = first; k < first + cnt; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_beat(tap_val(mode, k), last_at_end && (k == first + cnt - 1));
    end
  endtask

  task automatic do_swap(input int mode, input string name);
    exp_q.push_back({1'b0, pack_set(mode)});
    swap_en = 1'b1;
    @(posedge clk);
    #1;
    swap_en = 1'b0;
    model_active = pack_set(mode);
    check({name, "_live"}, coeffs_out, model_active);
    check({name, "_ready_back"}, FLAT'(coef_ready), FLAT'(1));
  endtask

  always @(negedge clk) begin
    if (reset && (load_done || load_err)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got done=%b err=%b, want no pulse", load_done, load_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (load_done === !mon_e.is_err && load_err === mon_e.is_err && coeffs_out === mon_e.coeffs)
          n_pass++;
        else
          $display("FAIL pulse: got done=%b err=%b coeffs=%h want err=%b coeffs=%h",
                   load_done, load_err, coeffs_out, mon_e.is_err, mon_e.coeffs);
      end
    end
  end

  initial begin
    #12;
    check("rst_coeffs", coeffs_out, '0);
    check("rst_ready", FLAT'(coef_ready), FLAT'(1));
    check("rst_pulses", FLAT'({load_done, load_err}), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Full set, swap withheld for 10 cycles
    send_beats(0, 0, N, 1'b1, 0);
    idle(10);
    check("armed_hold_coeffs", coeffs_out, '0);
    check("armed_not_ready", FLAT'(coef_ready), FLAT'(0));
    do_swap(0, "set_a");
    check("set_a_tap52", FLAT'(coeffs_out[52*W +: W]), FLAT'(53));

    // Short set: 10 beats, last on beat 10
    send_beats(1, 0, 9, 1'b0, 0);
    exp_q.push_back({1'b1, model_active});
    send_beat(tap_val(1, 9), 1'b1);
    idle(1);
    check("short_unchanged", coeffs_out, model_active);
    send_beats(1, 0, N, 1'b1, 0);
    do_swap(1, "after_short");

    // Overlong set: 53 beats, none last
    send_beats(2, 0, N - 1, 1'b0, 0);
    exp_q.push_back({1'b1, model_active});
    send_beat(tap_val(2, N - 1), 1'b0);
    check("overlong_idle_ready", FLAT'(coef_ready), FLAT'(1));
    idle(1);
    check("overlong_unchanged", coeffs_out, model_active);

    // Random gaps with swap_en held high throughout the load
    swap_en = 1'b1;
    exp_q.push_back({1'b0, pack_set(3)});
    send_beats(3, 0, N, 1'b1, 3);
    check("held_swap_not_same_edge", coeffs_out, model_active);
    check("held_swap_no_done_yet", FLAT'(load_done), FLAT'(0));
    @(posedge clk);
    #1;
    swap_en = 1'b0;
    model_active = pack_set(3);
    check("held_swap_live", coeffs_out, model_active);

    // coef_valid in ARMED must not be accepted
    send_beats(4, 0, N, 1'b1, 0);
    coef_data  = 16'h5555;
    coef_last  = 1'b1;
    coef_valid = 1'b1;
    idle(3);
    check("armed_ignores_valid", FLAT'(coef_ready), FLAT'(0));
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    do_swap(4, "after_armed_valid");

    // Back-to-back sets, next set's first beat in the load_done cycle
    send_beats(5, 0, N, 1'b1, 0);
    do_swap(5, "b2b_a");
    send_beats(6, 0, N, 1'b1, 0);
    do_swap(6, "b2b_b");

    // Reset mid-stream at beat 30
    send_beats(7, 0, 30, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_active = '0;
    check("midstream_rst_coeffs", coeffs_out, '0);
    check("midstream_rst_ready", FLAT'(coef_ready), FLAT'(1));
    check("midstream_rst_pulses", FLAT'({load_done, load_err}), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset while ARMED with a live set in place
    send_beats(0, 0, N, 1'b1, 0);
    do_swap(0, "pre_armed_rst");
    send_beats(2, 0, N, 1'b1, 0);
    check("armed_before_rst", FLAT'(coef_ready), FLAT'(0));
    #2;
    reset = 1'b0;
    #1;
    model_active = '0;
    check("armed_rst_coeffs", coeffs_out, '0);
    check("armed_rst_ready", FLAT'(coef_ready), FLAT'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);

    check("scoreboard_drained", FLAT'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
